// File: rtl/prog_loader.sv
// Byte-stream program loader: drives MAR/RAM strobes on the system bus.
// Optional trailing checksum byte is compiled in with LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter logic [7:0] START_ADDR = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] bus_out,
  output logic        bus_oe,
  output logic        mar_we,
  output logic        ram_we,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_RX      = 3'd2;
  localparam logic [2:0] S_SET_MAR = 3'd3;
  localparam logic [2:0] S_WR_RAM  = 3'd4;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK     = 3'd5;
`endif
  localparam logic [2:0] S_FIN     = 3'd6;

  logic [2:0] state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] count_q, count_d;
  logic [7:0] data_q, data_d;
  logic       xfer;

  assign xfer = in_valid && in_ready;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    data_d  = data_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LEN;
          addr_d  = START_ADDR;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = 8'h00;
          err_d   = 1'b0;
`endif
        end
      end
      S_LEN: begin
        if (xfer) begin
          count_d = in_data;
          state_d = S_RX;
        end
      end
      S_RX: begin
        if (xfer) begin
          data_d  = in_data;
          state_d = S_SET_MAR;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = sum_q + in_data;
`endif
        end
      end
      S_SET_MAR: state_d = S_WR_RAM;
      S_WR_RAM: begin
        addr_d  = addr_q + 8'd1;
        count_d = count_q - 8'd1;
        // a length of 0 counts down through FF, giving 256 bytes
        if (count_q != 8'd1) begin
          state_d = S_RX;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_FIN;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          err_d   = (in_data != sum_q);
          state_d = S_FIN;
        end
      end
`endif
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= 8'h00;
      count_q <= 8'h00;
      data_q  <= 8'h00;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= 8'h00;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      data_q  <= data_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    in_ready = (state_q == S_LEN) || (state_q == S_RX);
`ifdef LOADER_CHECKSUM_EN
    in_ready = in_ready || (state_q == S_CHK);
`endif
  end

  assign mar_we   = (state_q == S_SET_MAR);
  assign ram_we   = (state_q == S_WR_RAM);
  assign bus_oe   = mar_we || ram_we;
  assign bus_out  = mar_we ? {8'h00, addr_q} :
                    ram_we ? {8'h00, data_q} : 16'h0000;
  assign busy     = (state_q != S_IDLE);
  assign cpu_hold = busy;
  assign done     = (state_q == S_FIN);

`ifdef LOADER_CHECKSUM_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: two instances (base 00 and FE)
// sharing the byte stream, each with a small MAR/RAM bus model.
module tb_prog_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start0, start1, in_valid;
  logic [7:0] in_data;

  logic        rdy0, oe0, mw0, rw0, hold0, busy0, done0, err0;
  logic        rdy1, oe1, mw1, rw1, hold1, busy1, done1, err1;
  logic [15:0] bus0, bus1;

  prog_loader #(.START_ADDR(8'h00)) u0 (
    .clk(clk), .rst(rst), .start(start0),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
    .bus_out(bus0), .bus_oe(oe0), .mar_we(mw0), .ram_we(rw0),
    .cpu_hold(hold0), .busy(busy0), .done(done0), .err(err0)
  );

  prog_loader #(.START_ADDR(8'hFE)) u1 (
    .clk(clk), .rst(rst), .start(start1),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
    .bus_out(bus1), .bus_oe(oe1), .mar_we(mw1), .ram_we(rw1),
    .cpu_hold(hold1), .busy(busy1), .done(done1), .err(err1)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int t0   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mar0, mar1;
  logic [7:0] ram0 [256];
  logic [7:0] ram1 [256];
  int         wcnt0 [256];
  logic [7:0] mlog0 [$];
  int mw_n0 = 0, rw_n0 = 0, done_n0 = 0, viol0 = 0, done_cyc0 = 0;
  int rw_n1 = 0, done_n1 = 0, viol1 = 0;

  always @(negedge clk) begin
    if (mw0) begin
      mar0 = bus0[7:0];
      mlog0.push_back(bus0[7:0]);
      mw_n0++;
    end
    if (rw0) begin
      ram0[mar0] = bus0[7:0];
      wcnt0[mar0]++;
      rw_n0++;
    end
    if (done0) begin
      done_n0++;
      done_cyc0 = cyc;
    end
    if ((mw0 && rw0) || ((mw0 || rw0) && !oe0) ||
        (hold0 != busy0) || (bus0[15:8] != 8'h00))
      viol0++;
  end

  always @(negedge clk) begin
    if (mw1) mar1 = bus1[7:0];
    if (rw1) begin
      ram1[mar1] = bus1[7:0];
      rw_n1++;
    end
    if (done1) done_n1++;
    if ((mw1 && rw1) || ((mw1 || rw1) && !oe1) ||
        (hold1 != busy1) || (bus1[15:8] != 8'h00))
      viol1++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int w);
    if (w == 0) start0 = 1'b1;
    else        start1 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
    t0 = cyc;
  endtask

  task automatic send(input int w, input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!((w == 0) ? rdy0 : rdy1) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("send_timeout", 32'd1, 32'd0);
    tick();
    in_valid = 1'b0;
  endtask

  // checksum byte only exists in the checksum build
  task automatic send_ck(input int w, input logic [7:0] s);
`ifdef LOADER_CHECKSUM_EN
    send(w, s);
`else
    if (w < 0) send(w, s);
`endif
  endtask

  task automatic wait_done(input int w);
    int d, n;
    d = (w == 0) ? done_n0 : done_n1;
    n = 0;
    while (((w == 0) ? done_n0 : done_n1) == d && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check("done_timeout", 32'd1, 32'd0);
  endtask

  int m0, r0, d0, bad;

  initial begin
    for (int i = 0; i < 256; i++) wcnt0[i] = 0;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    in_valid = 1'b0; in_data = 8'h00;
    repeat (3) tick();
    check("reset_outs0",
          {rdy0, oe0, mw0, rw0, hold0, busy0, done0, err0, bus0}, 0);
    check("reset_outs1",
          {rdy1, oe1, mw1, rw1, hold1, busy1, done1, err1, bus1}, 0);
    rst = 1'b0;
    tick();
    check("idle_no_ready", rdy0, 0);

    // basic load 03,AA,BB,CC
    mlog0.delete();
    m0 = mw_n0; r0 = rw_n0; d0 = done_n0;
    pulse_start(0);
    check("busy_after_start", {busy0, hold0}, 2'b11);
    send(0, 8'h03); send(0, 8'hAA);
    send(0, 8'hBB); send(0, 8'hCC);
    send_ck(0, 8'h31);
    wait_done(0);
    check("load_ram0", ram0[0], 8'hAA);
    check("load_ram1", ram0[1], 8'hBB);
    check("load_ram2", ram0[2], 8'hCC);
    check("load_mar_n", mw_n0 - m0, 3);
    check("load_ram_n", rw_n0 - r0, 3);
    check("load_done_n", done_n0 - d0, 1);
    check("load_mar_addr",
          {mlog0[0], mlog0[1], mlog0[2]}, 24'h000102);
`ifndef LOADER_CHECKSUM_EN
    check("load_done_lat", done_cyc0 - t0, 10);
`endif
    check("idle_after_load", busy0, 0);

    // wrap from FE
    pulse_start(1);
    send(1, 8'h03); send(1, 8'h11);
    send(1, 8'h22); send(1, 8'h33);
    send_ck(1, 8'h66);
    wait_done(1);
    check("wrap_fe", ram1[8'hFE], 8'h11);
    check("wrap_ff", ram1[8'hFF], 8'h22);
    check("wrap_00", ram1[8'h00], 8'h33);
    check("wrap_ram_n", rw_n1, 3);

    // full 256-byte load
    for (int i = 0; i < 256; i++) wcnt0[i] = 0;
    r0 = rw_n0; d0 = done_n0;
    pulse_start(0);
    send(0, 8'h00);
    for (int i = 0; i < 256; i++) send(0, 8'(i) ^ 8'h3C);
    send_ck(0, 8'h80);
    wait_done(0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (wcnt0[i] != 1) bad++;
    check("full_ram_n", rw_n0 - r0, 256);
    check("full_once", bad, 0);
    check("full_done_n", done_n0 - d0, 1);
    check("full_ram_00", ram0[8'h00], 8'h3C);
    check("full_ram_80", ram0[8'h80], 8'hBC);
    check("full_ram_ff", ram0[8'hFF], 8'hC3);

    // backpressure, ignored start, abort in SET_MAR
    d0 = done_n0;
    pulse_start(0);
    send(0, 8'h03); send(0, 8'h5A);
    tick(); tick();
    m0 = mw_n0; r0 = rw_n0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (4) tick();
    check("bp_no_strobe", (mw_n0 - m0) + (rw_n0 - r0), 0);
    check("bp_wait_rx", {busy0, rdy0}, 2'b11);
    send(0, 8'hA5);
    tick(); tick();
    send(0, 8'h77);
    check("abort_in_setmar", mw0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    r0 = rw_n0;
    check("abort_idle", {busy0, hold0, oe0, rdy0}, 0);
    repeat (5) tick();
    check("abort_no_ram_we", rw_n0 - r0, 0);
    check("abort_no_done", done_n0 - d0, 0);
    check("ign_start_b0", ram0[0], 8'h5A);
    check("ign_start_b1", ram0[1], 8'hA5);
    check("abort_b2_kept", ram0[2], 8'h3E);

`ifdef LOADER_CHECKSUM_EN
    pulse_start(0);
    send(0, 8'h02); send(0, 8'h10);
    send(0, 8'h20); send(0, 8'h30);
    wait_done(0);
    check("ck_good_err", err0, 0);
    d0 = done_n0;
    pulse_start(0);
    send(0, 8'h02); send(0, 8'h10);
    send(0, 8'h20); send(0, 8'h31);
    wait_done(0);
    check("ck_bad_err", err0, 1);
    check("ck_bad_done", done_n0 - d0, 1);
    tick();
    check("ck_err_sticky", err0, 1);
    pulse_start(0);
    check("ck_err_clr", err0, 0);
    send(0, 8'h01); send(0, 8'h05); send(0, 8'h05);
    wait_done(0);
    check("ck_err_after", err0, 0);
`else
    check("err_tied_low", {err0, err1}, 0);
`endif

    check("invariants0", viol0, 0);
    check("invariants1", viol1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
